// File: rtl/lab3_params.sv
// Shared raster timing defaults and helpers for the lab3 video blocks.
// Defaults describe 640x480@60 with a 25.175 MHz pixel rate.
package lab3_params;

  typedef struct packed {
    int visible;
    int fp;
    int sync;
    int bp;
  } timing_t;

  localparam timing_t H_TIMING_640 = '{visible: 640, fp: 16, sync: 96, bp: 48};
  localparam timing_t V_TIMING_480 = '{visible: 480, fp: 10, sync: 2,  bp: 33};

  function automatic int timing_total(timing_t t);
    return t.visible + t.fp + t.sync + t.bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Width x depth shift register that advances only on en; depth 0 is a wire.
// Used for sync/de alignment and later for the pixel data path.
module vga_delay_line #(
  parameter int               WIDTH = 1,
  parameter int               DEPTH = 2,
  parameter logic [WIDTH-1:0] INIT  = '0
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= INIT;
        end else if (en) begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: fetch coordinates lead the
// sync/de outputs by LATENCY pixel slots to hide framebuffer read latency.
module vga_timing_gen
  import lab3_params::*;
#(
  parameter int H_VISIBLE = H_TIMING_640.visible,
  parameter int H_FP      = H_TIMING_640.fp,
  parameter int H_SYNC    = H_TIMING_640.sync,
  parameter int H_BP      = H_TIMING_640.bp,
  parameter int V_VISIBLE = V_TIMING_480.visible,
  parameter int V_FP      = V_TIMING_480.fp,
  parameter int V_SYNC    = V_TIMING_480.sync,
  parameter int V_BP      = V_TIMING_480.bp,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int LATENCY   = 2,
  parameter int FCNT_W    = 8,
  localparam int H_TOTAL  = timing_total(timing_t'{H_VISIBLE, H_FP, H_SYNC, H_BP}),
  localparam int V_TOTAL  = timing_total(timing_t'{V_VISIBLE, V_FP, V_SYNC, V_BP}),
  localparam int XW       = $clog2(H_TOTAL),
  localparam int YW       = $clog2(V_TOTAL)
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic              run,
  output logic [XW-1:0]     req_x,
  output logic [YW-1:0]     req_y,
  output logic              req_valid,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              line_start,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt
);

  generate
    if (H_VISIBLE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_VISIBLE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
      $error("vga_timing_gen: visible, porch and sync lengths must all be >= 1");
    end
    if (LATENCY < 0 || LATENCY > 8) begin : g_bad_latency
      $error("vga_timing_gen: LATENCY must be in 0..8");
    end
  endgenerate

  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT    = XW'(H_VISIBLE);
  localparam logic [XW-1:0] HS_BEGIN = XW'(H_VISIBLE + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT    = YW'(V_VISIBLE);
  localparam logic [YW-1:0] VS_BEGIN = YW'(V_VISIBLE + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_VISIBLE + V_FP + V_SYNC);

  logic [XW-1:0] hcnt;
  logic [YW-1:0] vcnt;
  logic          advance;
  logic          h_wrap;
  logic          v_wrap;

  assign advance = pix_en && run;
  assign h_wrap  = (hcnt == H_LAST);
  assign v_wrap  = (vcnt == V_LAST);

  // Strobes flag the update that entered hcnt=0; run=0 parks at the origin silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt        <= '0;
      vcnt        <= '0;
      frame_cnt   <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= advance && h_wrap;
      frame_start <= advance && h_wrap && v_wrap;
      if (pix_en) begin
        if (!run) begin
          hcnt <= '0;
          vcnt <= '0;
        end else if (h_wrap) begin
          hcnt <= '0;
          if (v_wrap) begin
            vcnt      <= '0;
            frame_cnt <= frame_cnt + 1'b1;
          end else begin
            vcnt <= vcnt + 1'b1;
          end
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end
    end
  end

  logic       hsync_raw;
  logic       vsync_raw;
  logic       valid_raw;
  logic [2:0] raw_bus;
  logic [2:0] dly_bus;

  assign hsync_raw = (hcnt >= HS_BEGIN) && (hcnt < HS_END);
  assign vsync_raw = (vcnt >= VS_BEGIN) && (vcnt < VS_END);
  assign valid_raw = (hcnt < H_ACT) && (vcnt < V_ACT);

  assign req_x     = hcnt;
  assign req_y     = vcnt;
  assign req_valid = valid_raw;

  // Polarity is applied before the delay so reset can preload idle output levels.
  assign raw_bus = {hsync_raw ? HSYNC_POL : ~HSYNC_POL,
                    vsync_raw ? VSYNC_POL : ~VSYNC_POL,
                    valid_raw};

  vga_delay_line #(
    .WIDTH (3),
    .DEPTH (LATENCY),
    .INIT  ({~HSYNC_POL, ~VSYNC_POL, 1'b0})
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .din   (raw_bus),
    .dout  (dly_bus)
  );

  assign hsync = dly_bus[2];
  assign vsync = dly_bus[1];
  assign de    = dly_bus[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 mode plus two small
// 12x7 modes (LATENCY=3, and active-high syncs with a 2-bit frame counter).
module tb_vga_timing_gen;

  logic clk;
  logic rst_n;
  logic pix_en;
  logic run;

  int total = 0;
  int bad   = 0;

  logic [9:0] def_x;
  logic [9:0] def_y;
  logic       def_rv, def_hs, def_vs, def_de, def_ls, def_fs;
  logic [7:0] def_fc;

  logic [3:0] lat_x;
  logic [2:0] lat_y;
  logic       lat_rv, lat_hs, lat_vs, lat_de, lat_ls, lat_fs;
  logic [7:0] lat_fc;

  logic [3:0] sml_x;
  logic [2:0] sml_y;
  logic       sml_rv, sml_hs, sml_vs, sml_de, sml_ls, sml_fs;
  logic [1:0] sml_fc;

  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .run(run),
    .req_x(def_x), .req_y(def_y), .req_valid(def_rv),
    .hsync(def_hs), .vsync(def_vs), .de(def_de),
    .line_start(def_ls), .frame_start(def_fs), .frame_cnt(def_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .LATENCY(3)
  ) u_lat (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .run(run),
    .req_x(lat_x), .req_y(lat_y), .req_valid(lat_rv),
    .hsync(lat_hs), .vsync(lat_vs), .de(lat_de),
    .line_start(lat_ls), .frame_start(lat_fs), .frame_cnt(lat_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .FCNT_W(2)
  ) u_sml (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .run(run),
    .req_x(sml_x), .req_y(sml_y), .req_valid(sml_rv),
    .hsync(sml_hs), .vsync(sml_vs), .de(sml_de),
    .line_start(sml_ls), .frame_start(sml_fs), .frame_cnt(sml_fc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic r, input logic p, input logic ru);
    rst_n  = r;
    pix_en = p;
    run    = ru;
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Small 12x7 mode reference: count index c -> (h, v) -> raw timing levels.
  function automatic logic smallValid(int c);
    int h = c % 12;
    int v = (c / 12) % 7;
    return (h < 8) && (v < 4);
  endfunction

  function automatic logic smallHsync(int c);
    int h = c % 12;
    return (h == 9) || (h == 10);
  endfunction

  function automatic logic smallVsync(int c);
    int v = (c / 12) % 7;
    return v == 5;
  endfunction

  initial begin
    int hs_cnt, hs_first, hs_last, de_cnt, vs_low, ls_cnt, fs_cnt, ls_first, ls_second;

    $display("[TB] reset values");
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepClk();
    stepClk();
    checkOutput("rst_def_hsync", 32'(def_hs), 1);
    checkOutput("rst_def_vsync", 32'(def_vs), 1);
    checkOutput("rst_def_de",    32'(def_de), 0);
    checkOutput("rst_def_ls",    32'(def_ls), 0);
    checkOutput("rst_def_fs",    32'(def_fs), 0);
    checkOutput("rst_def_rv",    32'(def_rv), 1);
    checkOutput("rst_def_x",     32'(def_x),  0);
    checkOutput("rst_def_y",     32'(def_y),  0);
    checkOutput("rst_def_fc",    32'(def_fc), 0);
    checkOutput("rst_sml_hsync", 32'(sml_hs), 0);
    checkOutput("rst_sml_vsync", 32'(sml_vs), 0);

    $display("[TB] default mode, two lines at one pixel per clk");
    hs_cnt = 0; hs_first = -1; hs_last = -1; de_cnt = 0; vs_low = 0; ls_cnt = 0; fs_cnt = 0;
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int n = 1; n <= 1601; n++) begin
      stepClk();
      if (n <= 800) begin
        if (!def_hs) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = n;
          hs_last = n;
        end
        if (def_de) de_cnt++;
      end
      if (!def_vs) vs_low++;
      if (def_ls) ls_cnt++;
      if (def_fs) fs_cnt++;
      if (n == 100) begin
        checkOutput("def_x_100", 32'(def_x), 100);
        checkOutput("def_y_100", 32'(def_y), 0);
      end
      if (n == 800) begin
        checkOutput("def_ls_800", 32'(def_ls), 1);
        checkOutput("def_x_800",  32'(def_x),  0);
        checkOutput("def_y_800",  32'(def_y),  1);
      end
      if (n == 801) checkOutput("def_ls_801", 32'(def_ls), 0);
      if (n == 1600) begin
        checkOutput("def_ls_1600", 32'(def_ls), 1);
        checkOutput("def_y_1600",  32'(def_y),  2);
      end
    end
    checkOutput("def_hs_low_count", 32'(hs_cnt),   96);
    checkOutput("def_hs_first",     32'(hs_first), 658);
    checkOutput("def_hs_last",      32'(hs_last),  753);
    checkOutput("def_de_count",     32'(de_cnt),   640);
    checkOutput("def_vs_low",       32'(vs_low),   0);
    checkOutput("def_ls_count",     32'(ls_cnt),   2);
    checkOutput("def_fs_count",     32'(fs_cnt),   0);

    $display("[TB] default mode, pix_en every 4th clk");
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepClk();
    stepClk();
    ls_cnt = 0; ls_first = -1; ls_second = -1;
    for (int c = 1; c <= 6404; c++) begin
      applyStimulus(1'b1, (c % 4) == 0, 1'b1);
      stepClk();
      if (def_ls) begin
        ls_cnt++;
        if (ls_first < 0) ls_first = c;
        else ls_second = c;
      end
      if (c == 401) checkOutput("slow_x_401", 32'(def_x), 100);
      if (c == 403) checkOutput("slow_x_403", 32'(def_x), 100);
      if (c == 404) checkOutput("slow_x_404", 32'(def_x), 101);
    end
    checkOutput("slow_ls_count",  32'(ls_cnt),    2);
    checkOutput("slow_ls_first",  32'(ls_first),  3200);
    checkOutput("slow_ls_second", 32'(ls_second), 6400);

    $display("[TB] small modes: LATENCY=3 alignment, active-high syncs, 2-bit frame counter");
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepClk();
    stepClk();
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int n = 1; n <= 430; n++) begin
      stepClk();
      if (n <= 90) begin
        if (n >= 3) begin
          checkOutput($sformatf("lat_de@%0d", n), 32'(lat_de), 32'(smallValid(n - 3)));
          checkOutput($sformatf("lat_hs@%0d", n), 32'(lat_hs), 32'(!smallHsync(n - 3)));
          checkOutput($sformatf("lat_vs@%0d", n), 32'(lat_vs), 32'(!smallVsync(n - 3)));
        end else begin
          checkOutput($sformatf("lat_de@%0d", n), 32'(lat_de), 0);
          checkOutput($sformatf("lat_hs@%0d", n), 32'(lat_hs), 1);
        end
      end
      if (n >= 2) begin
        checkOutput($sformatf("sml_de@%0d", n), 32'(sml_de), 32'(smallValid(n - 2)));
        checkOutput($sformatf("sml_hs@%0d", n), 32'(sml_hs), 32'(smallHsync(n - 2)));
        checkOutput($sformatf("sml_vs@%0d", n), 32'(sml_vs), 32'(smallVsync(n - 2)));
      end else begin
        checkOutput("sml_hs@1", 32'(sml_hs), 0);
      end
      checkOutput($sformatf("sml_x@%0d", n),  32'(sml_x),  32'(n % 12));
      checkOutput($sformatf("sml_y@%0d", n),  32'(sml_y),  32'((n / 12) % 7));
      checkOutput($sformatf("sml_ls@%0d", n), 32'(sml_ls), 32'((n % 12) == 0));
      checkOutput($sformatf("sml_fs@%0d", n), 32'(sml_fs), 32'((n % 84) == 0));
      checkOutput($sformatf("sml_fc@%0d", n), 32'(sml_fc), 32'((n / 84) % 4));
    end

    $display("[TB] run dropped mid-line for 50 slots");
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepClk();
    stepClk();
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int n = 1; n <= 29; n++) stepClk();
    checkOutput("run_pre_x", 32'(sml_x), 5);
    checkOutput("run_pre_y", 32'(sml_y), 2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 50; k++) begin
      stepClk();
      checkOutput($sformatf("stop_x@%0d", k),  32'(sml_x),  0);
      checkOutput($sformatf("stop_y@%0d", k),  32'(sml_y),  0);
      checkOutput($sformatf("stop_ls@%0d", k), 32'(sml_ls), 0);
      checkOutput($sformatf("stop_fs@%0d", k), 32'(sml_fs), 0);
      checkOutput($sformatf("stop_fc@%0d", k), 32'(sml_fc), 0);
      if (k >= 2) checkOutput($sformatf("stop_hs@%0d", k), 32'(sml_hs), 0);
    end
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int n = 1; n <= 84; n++) begin
      stepClk();
      checkOutput($sformatf("restart_fs@%0d", n), 32'(sml_fs), 32'(n == 84));
      checkOutput($sformatf("restart_ls@%0d", n), 32'(sml_ls), 32'((n % 12) == 0));
    end
    checkOutput("restart_fc", 32'(sml_fc), 1);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepClk();
    stepClk();
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int n = 1; n <= 231; n++) stepClk();
    checkOutput("mid_sml_x",  32'(sml_x),  3);
    checkOutput("mid_sml_y",  32'(sml_y),  5);
    checkOutput("mid_sml_fc", 32'(sml_fc), 2);
    checkOutput("mid_sml_vs", 32'(sml_vs), 1);
    checkOutput("mid_def_x",  32'(def_x),  231);
    applyStimulus(1'b0, 1'b1, 1'b1);
    stepClk();
    checkOutput("mrst_sml_hs", 32'(sml_hs), 0);
    checkOutput("mrst_sml_vs", 32'(sml_vs), 0);
    checkOutput("mrst_sml_de", 32'(sml_de), 0);
    checkOutput("mrst_sml_ls", 32'(sml_ls), 0);
    checkOutput("mrst_sml_fs", 32'(sml_fs), 0);
    checkOutput("mrst_sml_rv", 32'(sml_rv), 1);
    checkOutput("mrst_sml_x",  32'(sml_x),  0);
    checkOutput("mrst_sml_y",  32'(sml_y),  0);
    checkOutput("mrst_sml_fc", 32'(sml_fc), 0);
    checkOutput("mrst_def_hs", 32'(def_hs), 1);
    checkOutput("mrst_def_vs", 32'(def_vs), 1);
    checkOutput("mrst_def_de", 32'(def_de), 0);
    checkOutput("mrst_def_rv", 32'(def_rv), 1);
    checkOutput("mrst_def_x",  32'(def_x),  0);
    checkOutput("mrst_def_y",  32'(def_y),  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/raster timing generator for any mode, not only 640x480.
- Runs on the system clock, advancing one pixel per pix_en pulse.
- Issues pixel fetch coordinates LATENCY pixel slots ahead of the matching sync and data-enable outputs, so a framebuffer or ROM with fixed read latency lines up with the display.
- Also provides line/frame strobes, a frame counter and a run/stop control; sits between the pixel-enable divider and the video output stage.

Parameters:
- H_VISIBLE, 640: active pixels per line
- H_FP, 16: horizontal front porch, pixels
- H_SYNC, 96: hsync pulse width, pixels
- H_BP, 48: horizontal back porch, pixels
- V_VISIBLE, 480: active lines per frame
- V_FP, 10: vertical front porch, lines
- V_SYNC, 2: vsync pulse width, lines
- V_BP, 33: vertical back porch, lines
- HSYNC_POL, 0: asserted level of hsync (0 = active-low)
- VSYNC_POL, 0: asserted level of vsync
- LATENCY, 2: pix_en slots between req_* and sync/de outputs; legal range 0..8
- FCNT_W, 8: frame counter width

Ports:
- clk, input, 1: system clock
- rst_n, input, 1: synchronous active-low reset
- pix_en, input, 1: pixel-slot enable, one clk wide
- run, input, 1: 1 = generate; 0 = hold at frame origin
- req_x, output, XW: fetch column, XW = $clog2(H_TOTAL)
- req_y, output, YW: fetch row, YW = $clog2(V_TOTAL)
- req_valid, output, 1: fetch coordinate is in the visible area
- hsync, output, 1: horizontal sync, delayed by LATENCY
- vsync, output, 1: vertical sync, delayed by LATENCY
- de, output, 1: data enable (visible), delayed by LATENCY
- line_start, output, 1: one-clk pulse when the counter enters hcnt=0
- frame_start, output, 1: one-clk pulse when the counter enters hcnt=0, vcnt=0
- frame_cnt, output, FCNT_W: completed frames, wraps

Behaviour:
- Derived totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP; V_TOTAL likewise from the V_* values.
- Counters hcnt/vcnt advance only when pix_en=1 and run=1.
  - hcnt wraps H_TOTAL-1 -> 0; vcnt increments on each hcnt wrap.
  - vcnt wraps V_TOTAL-1 -> 0; frame_cnt increments on that wrap, modulo 2^FCNT_W.
- Raw sync timing:
  - hsync_raw is asserted for hcnt in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC).
  - vsync_raw uses the same window on vcnt with the V_* values.
  - Output level = POL when asserted, ~POL otherwise.
- Request outputs:
  - req_x = hcnt and req_y = vcnt, combinational from the counters.
  - req_valid = (hcnt < H_VISIBLE) && (vcnt < V_VISIBLE).
- Delay line:
  - hsync, vsync and de come from a LATENCY-deep shift register of {hsync_raw, vsync_raw, valid_raw}.
  - The register shifts only on pix_en (regardless of run); outputs are registered.
  - LATENCY=0 means a direct combinational path from the raw signals.
- Strobes:
  - line_start and frame_start are registered and asserted for exactly one clk, the cycle after the counter update that entered the relevant count.
  - The first strobe after reset occurs on the first advance out of the last pixel of a line/frame; reset itself produces no strobe.
- run=0:
  - On the next pix_en, hcnt and vcnt load 0 and stay there.
  - No strobes and no frame_cnt change; the delay line keeps shifting in the deasserted sync values.
  - Re-asserting run restarts from pixel (0,0); the first frame_start follows the first full frame.
- Reset (rst_n=0 on a clk edge), from any state including mid-line:
  - hcnt, vcnt and frame_cnt = 0; delay line filled with deasserted values.
  - Outputs: hsync=~HSYNC_POL, vsync=~VSYNC_POL, de=0, line_start=0, frame_start=0, req_valid=1, req_x=0, req_y=0.
- pix_en held high permanently is legal: one pixel per clk.
- Elaboration checks: every porch/sync/visible parameter must be >=1, and LATENCY must be <=8; otherwise $error.

Decomposition:
- lab3_params package holds:
  - the 640x480@60 constants as defaults;
  - a timing struct typedef (visible, fp, sync, bp);
  - a function computing the total.
- One sub-module: vga_delay_line, a parametrised width x depth shift register clocked by enable. It is reused later for the pixel data path.

Test Plan:
- Reset, then 1 full frame with pix_en=1 every clk, defaults:
  - hsync low exactly for hcnt 656..751 on every line;
  - vsync low for lines 490..491;
  - 307200 de cycles per frame;
  - frame_start after 420000 pixel slots.
- LATENCY=3: each req_valid rising edge is followed by a de rising edge exactly 3 pix_en slots later; the same offset holds for hsync.
- pix_en every 4th clk: counters hold between enables; line_start is 1 clk wide and 3200 clk apart.
- HSYNC_POL=1, VSYNC_POL=1, small mode (8/1/2/1 by 4/1/1/1):
  - hsync high at hcnt 9..10;
  - H_TOTAL=12, V_TOTAL=7, frame period 84 slots.
- run dropped mid-line at (100,37) for 50 slots, then raised:
  - req_x=req_y=0 held while run=0;
  - no strobes;
  - frame_cnt unchanged;
  - next frame_start 420000 slots after restart.
- rst_n low mid-frame at (300,200): next cycle all outputs at the reset values above, frame_cnt=0. Also FCNT_W=2 over 5 frames reads 1,2,3,0,1.
